// File: rtl/fb_pkg.sv
// Shared constants, pixel types and colour helpers for the paint framebuffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

    // Default visible raster geometry (VGA 640x480 driven from a 50 MHz clock).
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int X_OFFSET = 145;
    localparam int Y_OFFSET = 36;
    localparam int FB_WORDS = H_ACTIVE * V_ACTIVE;   // 307200 pixels

    // RGB333 field positions inside a framebuffer word.
    localparam int RGB_R_HI = 8;
    localparam int RGB_R_LO = 6;
    localparam int RGB_G_HI = 5;
    localparam int RGB_G_LO = 3;
    localparam int RGB_B_HI = 2;
    localparam int RGB_B_LO = 0;

    typedef logic [8:0] rgb333_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // 3-bit to 8-bit by bit replication: 0 maps to 0 and 7 maps to 255,
    // with an evenly spread ramp in between.
    function automatic logic [7:0] rgb333_expand(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic rgb888_t rgb333_to_888(input rgb333_t p);
        rgb888_t o;
        o.r = rgb333_expand(p[RGB_R_HI:RGB_R_LO]);
        o.g = rgb333_expand(p[RGB_G_HI:RGB_G_LO]);
        o.b = rgb333_expand(p[RGB_B_HI:RGB_B_LO]);
        return o;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Framebuffer read-address generator: incremental row base plus column, no multiplier.
// Latency: 1 cycle from raster position to o_read_addr / o_read_en / o_addr_vld.
// Backpressure: none; free-running, one address per clock.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ativo, i_x, i_y     raster visible flag and position from the VGA timing generator
//   o_read_en             registered copy of i_ativo (RAM read enable)
//   o_read_addr           registered row_base + column, held while i_ativo is low
//   o_addr_vld            o_read_en qualified by "row base is known good this frame"
module fb_addr_gen #(
    parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
    parameter int X_OFFSET = fb_pkg::X_OFFSET,
    parameter int Y_OFFSET = fb_pkg::Y_OFFSET,
    parameter int ADDR_W   = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ativo,
    input  logic [10:0]       i_x,
    input  logic [10:0]       i_y,
    output logic              o_read_en,
    output logic [ADDR_W-1:0] o_read_addr,
    output logic              o_addr_vld
);

    // Largest legal row base: start of the last visible line.
    localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'((V_ACTIVE - 1) * H_ACTIVE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(H_ACTIVE - 1);

    logic [ADDR_W-1:0] r_row_base;
    logic [10:0]       r_y_prev;
    logic              r_synced;
    logic              r_read_en;
    logic [ADDR_W-1:0] r_read_addr;
    logic              r_addr_vld;

    logic signed [12:0] w_vx;
    logic [ADDR_W-1:0]  w_col;
    logic               w_y_first;
    logic               w_y_step;
    logic               w_synced;
    logic [ADDR_W-1:0]  w_row_base;

    assign w_vx = $signed({2'b00, i_x}) - $signed(13'(X_OFFSET));

    // Column clamped into the visible line so that a stray ativo outside the
    // active window can never push the address past the framebuffer end.
    always_comb begin
        w_col = '0;
        if (w_vx[12]) begin
            w_col = '0;
        end else if (w_vx > $signed(13'(H_ACTIVE - 1))) begin
            w_col = COL_MAX;
        end else begin
            w_col = ADDR_W'(w_vx[11:0]);
        end
    end

    assign w_y_first = (i_y == 11'(Y_OFFSET));
    assign w_y_step  = (i_y != r_y_prev) &&
                       (i_y >  11'(Y_OFFSET)) &&
                       (i_y <  11'(Y_OFFSET + V_ACTIVE));

    // Row base for the line being addressed this cycle. Used combinationally so
    // the first pixel after a line change already gets the new base. Saturation
    // keeps a post-reset, mid-frame run inside the framebuffer until the next
    // first line resynchronises it.
    always_comb begin
        w_row_base = r_row_base;
        if (w_y_first) begin
            w_row_base = '0;
        end else if (w_y_step) begin
            w_row_base = (r_row_base >= ROW_MAX) ? ROW_MAX : (r_row_base + ROW_STEP);
        end
    end

    // Once the first visible line has been seen, the row base tracks the raster.
    assign w_synced = r_synced | w_y_first;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row_base  <= '0;
            r_y_prev    <= '0;
            r_synced    <= 1'b0;
            r_read_en   <= 1'b0;
            r_read_addr <= '0;
            r_addr_vld  <= 1'b0;
        end else begin
            r_row_base <= w_row_base;
            r_y_prev   <= i_y;
            r_synced   <= w_synced;
            r_read_en  <= i_ativo;
            r_addr_vld <= i_ativo & w_synced;
            if (i_ativo) begin
                r_read_addr <= w_row_base + w_col;
            end
        end
    end

    assign o_read_en   = r_read_en;
    assign o_read_addr = r_read_addr;
    assign o_addr_vld  = r_addr_vld;

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: raster position -> RAM read -> overlays -> registered 8-bit RGB.
// Latency: 3 cycles from x/y/ativo to vga_r/g/b (address after 1, RAM data after 2).
// Backpressure: none; one pixel per clock, RAM read data expected exactly 1 cycle after read_en.
//
// Ports:
//   CLOCK_50, reset                 clock, synchronous active-high reset
//   ativo, x, y                     raster visible flag and position
//   cursor_x, cursor_y, radius      crosshair cursor in visible coordinates
//   preview_en, preview_color       full-screen colour preview (RGB333)
//   ram_data                        RGB333 read data from the framebuffer RAM
//   read_en, read_addr              framebuffer RAM read port
//   vga_r, vga_g, vga_b             registered pixel colour to the DAC
module fb_scanout #(
    parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
    parameter int X_OFFSET = fb_pkg::X_OFFSET,
    parameter int Y_OFFSET = fb_pkg::Y_OFFSET,
    parameter int ADDR_W   = 20
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              ativo,
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    input  logic [10:0]       cursor_x,
    input  logic [10:0]       cursor_y,
    input  logic [5:0]        radius,
    input  logic              preview_en,
    input  logic [8:0]        preview_color,
    input  logic [8:0]        ram_data,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_addr,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b
);

    import fb_pkg::*;

    // ---------------------------------------------------------------
    // Stage 0: address generation and overlay decision
    // ---------------------------------------------------------------
    logic w_vld0;

    fb_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .X_OFFSET (X_OFFSET),
        .Y_OFFSET (Y_OFFSET),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .i_clk       (CLOCK_50),
        .i_rst       (reset),
        .i_ativo     (ativo),
        .i_x         (x),
        .i_y         (y),
        .o_read_en   (read_en),
        .o_read_addr (read_addr),
        .o_addr_vld  (w_vld0)
    );

    // Signed 13-bit arithmetic: visible coordinates and cursor distances can be
    // negative near the screen edges, and must not wrap into the far side.
    logic signed [12:0] w_vx;
    logic signed [12:0] w_vy;
    logic signed [12:0] w_cx;
    logic signed [12:0] w_cy;
    logic signed [12:0] w_dx;
    logic signed [12:0] w_dy;
    logic signed [12:0] w_adx;
    logic signed [12:0] w_ady;
    logic signed [12:0] w_rad;
    logic               w_ovl;

    assign w_vx  = $signed({2'b00, x}) - $signed(13'(X_OFFSET));
    assign w_vy  = $signed({2'b00, y}) - $signed(13'(Y_OFFSET));
    assign w_cx  = $signed({2'b00, cursor_x});
    assign w_cy  = $signed({2'b00, cursor_y});
    assign w_rad = $signed({7'b0, radius});
    assign w_dx  = w_vx - w_cx;
    assign w_dy  = w_vy - w_cy;
    assign w_adx = w_dx[12] ? -w_dx : w_dx;
    assign w_ady = w_dy[12] ? -w_dy : w_dy;

    // Crosshair: vertical arm on the cursor column, horizontal arm on the cursor row.
    assign w_ovl = ((w_vx == w_cx) && (w_ady <= w_rad)) ||
                   ((w_vy == w_cy) && (w_adx <= w_rad));

    logic    r_ovl0;
    logic    r_prev0;
    rgb333_t r_pcol0;

    // ---------------------------------------------------------------
    // Stage 1: side-band delayed while the RAM performs its read
    // ---------------------------------------------------------------
    logic    r_vld1;
    logic    r_ovl1;
    logic    r_prev1;
    rgb333_t r_pcol1;

    // ---------------------------------------------------------------
    // Stage 2: colour select, registered straight to the DAC
    // ---------------------------------------------------------------
    rgb888_t r_rgb;
    rgb888_t w_rgb_nxt;

    always_comb begin
        w_rgb_nxt = '0;
        if (!r_vld1) begin
            w_rgb_nxt = '0;
        end else if (r_prev1) begin
            w_rgb_nxt = rgb333_to_888(r_pcol1);
        end else if (r_ovl1) begin
            w_rgb_nxt.r = 8'hFF;
            w_rgb_nxt.g = 8'h00;
            w_rgb_nxt.b = 8'h00;
        end else begin
            w_rgb_nxt = rgb333_to_888(ram_data);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_ovl0  <= 1'b0;
            r_prev0 <= 1'b0;
            r_pcol0 <= '0;
            r_vld1  <= 1'b0;
            r_ovl1  <= 1'b0;
            r_prev1 <= 1'b0;
            r_pcol1 <= '0;
            r_rgb   <= '0;
        end else begin
            r_ovl0  <= w_ovl;
            r_prev0 <= preview_en;
            r_pcol0 <= preview_color;
            r_vld1  <= w_vld0;
            r_ovl1  <= r_ovl0;
            r_prev1 <= r_prev0;
            r_pcol1 <= r_pcol0;
            r_rgb   <= w_rgb_nxt;
        end
    end

    assign vga_r = r_rgb.r;
    assign vga_g = r_rgb.g;
    assign vga_b = r_rgb.b;

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        ativo;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] cursor_x;
    logic [10:0] cursor_y;
    logic [5:0]  radius;
    logic        preview_en;
    logic [8:0]  preview_color;
    logic [8:0]  ram_data = 9'd0;
    logic        read_en;
    logic [19:0] read_addr;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    logic [8:0]  ram_word;
    logic [23:0] rgb;

    int total = 0;
    int bad   = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    always #10 CLOCK_50 = ~CLOCK_50;

    // Synchronous-read RAM stand-in: data one cycle after read_en.
    always @(posedge CLOCK_50) begin
        if (read_en) ram_data <= ram_word;
    end

    fb_scanout dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .ativo         (ativo),
        .x             (x),
        .y             (y),
        .cursor_x      (cursor_x),
        .cursor_y      (cursor_y),
        .radius        (radius),
        .preview_en    (preview_en),
        .preview_color (preview_color),
        .ram_data      (ram_data),
        .read_en       (read_en),
        .read_addr     (read_addr),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one visible pixel and wait the full pipeline latency.
    task automatic pix(input int vx, input int vy);
        ativo = 1'b1;
        x = 11'(vx + 145);
        y = 11'(vy + 36);
        tick();
        tick();
        tick();
    endtask

    int          tx [7];
    int          ty [7];
    logic [23:0] te [7];

    initial begin
        reset         = 1'b1;
        ativo         = 1'b1;
        x             = 11'd145;
        y             = 11'd36;
        cursor_x      = 11'd1000;
        cursor_y      = 11'd1000;
        radius        = 6'd0;
        preview_en    = 1'b0;
        preview_color = 9'd0;
        ram_word      = 9'd0;

        // Reset held with ativo high: nothing leaves the block.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_read_en", {31'd0, read_en}, 32'd0);
            chk("rst_rgb", {8'd0, rgb}, 32'd0);
        end
        chk("rst_read_addr", {12'd0, read_addr}, 32'd0);
        reset = 1'b0;

        // First visible pixel, latency and colour expansion.
        ram_word = 9'b111_011_000;
        tick();
        chk("addr_0_0", {12'd0, read_addr}, 32'd0);
        chk("read_en_on", {31'd0, read_en}, 32'd1);
        chk("lat_edge1", {8'd0, rgb}, 32'd0);
        tick();
        chk("lat_edge2", {8'd0, rgb}, 32'd0);
        tick();
        chk("lat_edge3_rgb", {8'd0, rgb}, 32'hFF6D00);

        ram_word = 9'd0;
        tick();
        tick();
        tick();
        chk("ram_zero_rgb", {8'd0, rgb}, 32'h000000);

        // Second line starts one row further on.
        y = 11'd37;
        tick();
        chk("addr_row1", {12'd0, read_addr}, 32'd640);

        // Address holds during blanking.
        ativo = 1'b0;
        x = 11'd0;
        tick();
        chk("addr_hold", {12'd0, read_addr}, 32'd640);
        chk("read_en_off", {31'd0, read_en}, 32'd0);

        // Walk every line down to the last one.
        for (int yy = 38; yy <= 515; yy++) begin
            y = 11'(yy);
            tick();
        end
        ativo = 1'b1;
        x = 11'd784;
        ram_word = 9'b101_110_010;
        tick();
        chk("addr_last", {12'd0, read_addr}, 32'd307199);
        tick();
        tick();
        chk("last_pix_rgb", {8'd0, rgb}, 32'hB6DB49);

        // Crosshair at (10,10), radius 3, on a green background.
        ram_word = 9'b000_111_000;
        cursor_x = 11'd10;
        cursor_y = 11'd10;
        radius   = 6'd3;
        tx = '{10, 10, 10,  7, 13,  6, 11};
        ty = '{ 7, 13, 14, 10, 10, 10, 11};
        te = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'hFF0000,
               24'hFF0000, 24'h00FF00, 24'h00FF00};
        for (int i = 0; i < 7; i++) begin
            pix(tx[i], ty[i]);
            chk($sformatf("cur10_%0d_%0d", tx[i], ty[i]), {8'd0, rgb}, {8'd0, te[i]});
        end

        // Crosshair at the origin: arms stop at the edge, no wrap.
        cursor_x = 11'd0;
        cursor_y = 11'd0;
        tx = '{0, 3, 4, 0, 639,   0, 2};
        ty = '{3, 0, 0, 4,   0, 479, 1};
        te = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'h00FF00,
               24'h00FF00, 24'h00FF00, 24'h00FF00};
        for (int i = 0; i < 7; i++) begin
            pix(tx[i], ty[i]);
            chk($sformatf("cur0_%0d_%0d", tx[i], ty[i]), {8'd0, rgb}, {8'd0, te[i]});
        end

        // Preview overrides the cursor and the RAM; blanking still wins.
        preview_en    = 1'b1;
        preview_color = 9'b000_000_111;
        pix(0, 0);
        chk("prev_on_cursor", {8'd0, rgb}, 32'h0000FF);
        pix(100, 100);
        chk("prev_plain", {8'd0, rgb}, 32'h0000FF);
        ativo = 1'b0;
        tick();
        tick();
        tick();
        chk("prev_blank", {8'd0, rgb}, 32'h000000);
        preview_en = 1'b0;

        // Mid-frame reset.
        cursor_x = 11'd1000;
        cursor_y = 11'd1000;
        ram_word = 9'b111_111_111;
        pix(0, 0);
        pix(155, 164);
        chk("pre_reset_rgb", {8'd0, rgb}, 32'hFFFFFF);
        reset = 1'b1;
        tick();
        chk("midrst_black", {8'd0, rgb}, 32'h000000);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_wait_black", {8'd0, rgb}, 32'h000000);
        chk("midrst_addr_range", {31'd0, (read_addr < 20'd307200)}, 32'd1);
        x = 11'd145;
        y = 11'd36;
        tick();
        chk("resync_addr", {12'd0, read_addr}, 32'd0);
        tick();
        tick();
        chk("resync_rgb", {8'd0, rgb}, 32'hFFFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
